// File: rtl/mips_pkg.sv
// Shared definitions for the fetch front end: widths, opcode field location,
// reset PC default and the fetch state encoding.
package mips_pkg;

  localparam int XLEN    = 32;
  localparam int ILEN    = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {instr, pc} pairs. Flush wins over push
// and pop. The head is read straight out of the storage registers, so there
// is no combinational path from the write side to the head outputs.
module fetch_buffer
  import mips_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [ILEN-1:0] push_instr,
  input  logic [XLEN-1:0] push_pc,
  output logic [ILEN-1:0] head_instr,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_pc_plus4,
  output logic [CW-1:0]   count,
  output logic            empty,
  output logic            full
);

  localparam int AW = $clog2(DEPTH);

  logic [ILEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_instr    = instr_q[rd_ptr];
  assign head_pc       = pc_q[rd_ptr];
  assign head_pc_plus4 = head_pc + 32'd4;

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      instr_q[wr_ptr] <= push_instr;
      pc_q[wr_ptr]    <= push_pc;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one instruction-memory
// request outstanding, and only issues a request when a buffer slot is
// guaranteed for its response, so the response side never needs backpressure.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | nothing pending; waiting for a free buffer slot
//   REQ   | request presented at imem_addr = pc, waiting for ready
//   WAIT  | one live response outstanding, will be buffered
//   DRAIN | one stale response outstanding (after redirect), discarded
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [ILEN-1:0]  imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ILEN-1:0]  out_instr,
  output logic [OPC_W-1:0] out_opcode,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_pc_plus4
);

  localparam int             CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(BUF_DEPTH);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_after_write;
  logic            buf_empty;
  logic            buf_full;
  logic            rsp_take;
  logic            pop;

  assign imem_addr  = pc;
  assign out_valid  = !buf_empty;
  assign pop        = out_valid && out_ready;
  assign out_opcode = out_instr[OPC_MSB:OPC_LSB];

  // A redirect in the response cycle makes that response stale as well.
  assign rsp_take = (state == WAIT) && imem_rsp_valid && !redirect_valid;

  // Occupancy once the current response lands, accounting for a same-cycle pop.
  assign count_after_write = count + 1'b1 - CW'(pop);

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk           (clk),
    .reset         (reset),
    .push          (rsp_take),
    .pop           (pop),
    .flush         (redirect_valid),
    .push_instr    (imem_rsp_data),
    .push_pc       (req_pc),
    .head_instr    (out_instr),
    .head_pc       (out_pc),
    .head_pc_plus4 (out_pc_plus4),
    .count         (count),
    .empty         (buf_empty),
    .full          (buf_full)
  );

  // Fetch sequencer: PC, request valid and state; redirect overrides normal flow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      imem_req_valid <= 1'b0;
      pc             <= RESET_PC;
      req_pc         <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= align_pc(redirect_pc);
      unique case (state)
        IDLE: begin
          state          <= REQ;
          imem_req_valid <= 1'b1;
        end
        REQ: begin
          if (imem_req_ready) begin
            state          <= DRAIN;
            imem_req_valid <= 1'b0;
          end else begin
            state          <= REQ;
            imem_req_valid <= 1'b1;
          end
        end
        WAIT, DRAIN: begin
          // A response arriving now is the stale one; nothing else is in flight.
          if (imem_rsp_valid) begin
            state          <= REQ;
            imem_req_valid <= 1'b1;
          end else begin
            state          <= DRAIN;
            imem_req_valid <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          imem_req_valid <= 1'b0;
        end
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (!buf_full) begin
            state          <= REQ;
            imem_req_valid <= 1'b1;
          end
        end
        REQ: begin
          if (imem_req_ready) begin
            req_pc         <= pc;
            pc             <= pc + 32'd4;
            state          <= WAIT;
            imem_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (count_after_write < DEPTH_C) begin
              state          <= REQ;
              imem_req_valid <= 1'b1;
            end else begin
              state          <= IDLE;
              imem_req_valid <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (imem_rsp_valid) begin
            state          <= REQ;
            imem_req_valid <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          imem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: an instruction memory model plus a reference
// model of the delivered instruction stream (expected buffer contents as a
// queue of {instr, pc}), compared against the DUT every cycle, with directed
// scenarios pinned by literal expectations and a randomized soak.
module tb_instr_fetch_unit;
  import mips_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [5:0]  out_opcode;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_opcode     (out_opcode),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  ent_t        q[$];
  logic [31:0] fetch_pc;
  logic [31:0] pend_pc;
  logic [31:0] mem_addr;
  bit          pend, stale, live, prev_hold, prev_reset;
  int          pend_wait;
  logic [31:0] prev_addr;

  // logs for directed literal checks
  logic [31:0] pop_log[$];
  logic [31:0] p4_log[$];
  logic [31:0] acc_log[$];
  logic [31:0] blocked_addrs[$];
  int          total_pops;

  // stimulus knobs
  int          p_ready, lat_min, lat_max, p_oready, p_redir, p_reset;
  bit          force_reset;
  logic [31:0] block_addr;
  int          block_left;
  bit          redir_in_wait, redir_on_rsp, redir_fired;
  logic [31:0] redir_target;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2002_0005;
    return (a * 32'h9E37_79B9) ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pop_at(input int i);
    return (i < pop_log.size()) ? pop_log[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] p4_at(input int i);
    return (i < p4_log.size()) ? p4_log[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] acc_at(input int i);
    return (i < acc_log.size()) ? acc_log[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic check_outputs();
    if (!live) return;
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_instr", out_instr, q[0].instr);
      chk("out_opcode", out_opcode, q[0].instr[31:26]);
      chk("out_pc_plus4", out_pc_plus4, q[0].pc + 32'd4);
    end
    if (prev_reset) chk("reset_req_valid", imem_req_valid, 0);
    if (prev_hold) begin
      chk("req_hold_valid", imem_req_valid, 1);
      chk("req_hold_addr", imem_addr, prev_addr);
    end
  endtask

  // One cycle: check outputs mid-cycle, drive inputs, advance the model to the next edge.
  task automatic step();
    bit          do_reset, do_redir, rsp_now, acc_now, pop_now, was_pend;
    int          qs0;
    logic [31:0] tgt;
    @(negedge clk);
    check_outputs();

    do_reset    = force_reset || (int'($urandom_range(999)) < p_reset);
    force_reset = 1'b0;
    rsp_now     = live && !do_reset && pend && (pend_wait == 0);

    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(mem_addr) : $urandom();
    imem_req_ready = int'($urandom_range(99)) < p_ready;
    if (imem_req_valid === 1'b1 && block_left > 0 && imem_addr == block_addr) begin
      imem_req_ready = 1'b0;
      block_left--;
      blocked_addrs.push_back(imem_addr);
    end
    out_ready = int'($urandom_range(99)) < p_oready;

    do_redir = int'($urandom_range(99)) < p_redir;
    tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
    if (redir_in_wait && pend && !rsp_now && pend_pc == 32'h4) begin
      do_redir = 1'b1; tgt = redir_target; redir_in_wait = 1'b0; redir_fired = 1'b1;
    end
    if (redir_on_rsp && rsp_now && pend_pc == 32'h4) begin
      do_redir = 1'b1; tgt = redir_target; redir_on_rsp = 1'b0; redir_fired = 1'b1;
    end
    if (do_reset) do_redir = 1'b0;
    redirect_valid = do_redir;
    redirect_pc    = tgt;
    reset          = do_reset;

    acc_now  = (imem_req_valid === 1'b1) && imem_req_ready;
    pop_now  = (out_valid === 1'b1) && out_ready;
    was_pend = pend;
    qs0      = q.size();

    if (do_reset) begin
      q.delete();
      pend = 0; stale = 0; fetch_pc = RPC; prev_hold = 0; prev_reset = 1; live = 1;
      pop_log.delete(); p4_log.delete(); acc_log.delete(); blocked_addrs.delete();
    end else if (live) begin
      prev_reset = 0;
      prev_hold  = (imem_req_valid === 1'b1) && !imem_req_ready && !do_redir;
      prev_addr  = imem_addr;
      if (pop_now && !do_redir) begin
        void'(q.pop_front());
        pop_log.push_back(out_pc);
        p4_log.push_back(out_pc_plus4);
        total_pops++;
      end
      if (rsp_now) begin
        if (!stale && !do_redir) q.push_back('{instr: mem_word(pend_pc), pc: pend_pc});
        pend = 0;
      end else if (pend) begin
        pend_wait--;
      end
      if (acc_now) begin
        chk("one_outstanding", was_pend, 0);
        chk("credit_slot_free", qs0 < DEPTH, 1);
        chk("req_addr", imem_addr, fetch_pc);
        acc_log.push_back(imem_addr);
        pend      = 1;
        pend_pc   = fetch_pc;
        mem_addr  = imem_addr;
        pend_wait = int'($urandom_range(lat_max, lat_min)) - 1;
        stale     = do_redir;
        fetch_pc  = fetch_pc + 32'd4;
      end
      if (do_redir) begin
        q.delete();
        fetch_pc = {tgt[31:2], 2'b00};
        if (pend) stale = 1;
        pop_log.delete(); p4_log.delete(); acc_log.delete();
      end
    end
  endtask

  task automatic directed_knobs();
    p_ready = 100; lat_min = 1; lat_max = 1; p_oready = 100; p_redir = 0; p_reset = 0;
    block_left = 0; redir_in_wait = 0; redir_on_rsp = 0; redir_fired = 0;
  endtask

  task automatic reset_seq();
    force_reset = 1'b1;
    step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    redirect_valid = 0; redirect_pc = 0; out_ready = 0;
    live = 0; pend = 0; stale = 0; prev_hold = 0; prev_reset = 0; fetch_pc = RPC;
    force_reset = 0; total_pops = 0; block_addr = 0; redir_target = 0;

    // reset release and first-instruction latency
    directed_knobs();
    reset_seq();
    step();                                   // cycle 0
    chk("t1_c0_req_valid", imem_req_valid, 0);
    step();                                   // cycle 1
    chk("t1_c1_req_valid", imem_req_valid, 1);
    chk("t1_c1_addr", imem_addr, 32'h0);
    step();                                   // cycle 2
    chk("t1_c2_out_valid", out_valid, 0);
    step();                                   // cycle 3
    chk("t1_c3_out_valid", out_valid, 1);
    chk("t1_c3_opcode", out_opcode, 6'b001000);
    chk("t1_c3_instr", out_instr, 32'h2002_0005);
    chk("t1_c3_pc", out_pc, 32'h0);
    chk("t1_c3_pc_plus4", out_pc_plus4, 32'h4);

    // straight-line stream
    run(12);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_seq%0d", i), pop_at(i), 32'(i * 4));

    // decode stalled: buffer fills, no further requests, head held
    directed_knobs();
    p_oready = 0;
    reset_seq();
    run(10);
    chk("t3_req_valid", imem_req_valid, 0);
    chk("t3_out_valid", out_valid, 1);
    chk("t3_head_pc", out_pc, 32'h0);
    chk("t3_nreq", acc_log.size(), 2);
    chk("t3_req1", acc_at(1), 32'h4);
    p_oready = 100;
    run(10);
    for (int i = 0; i < 3; i++) chk($sformatf("t3_seq%0d", i), pop_at(i), 32'(i * 4));

    // memory not ready for 5 cycles on addr 8
    directed_knobs();
    reset_seq();
    block_addr = 32'h8; block_left = 5;
    run(20);
    chk("t4_nblocked", blocked_addrs.size(), 5);
    for (int i = 0; i < 5 && i < blocked_addrs.size(); i++)
      chk($sformatf("t4_blocked%0d", i), blocked_addrs[i], 32'h8);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_acc%0d", i), acc_at(i), 32'(i * 4));

    // redirect while a response is outstanding
    directed_knobs();
    lat_min = 3; lat_max = 3;
    reset_seq();
    redir_target = 32'h0000_0403; redir_in_wait = 1;
    run(25);
    chk("t5_fired", redir_fired, 1);
    chk("t5_acc0", acc_at(0), 32'h0000_0400);
    chk("t5_pop0", pop_at(0), 32'h0000_0400);
    chk("t5_pop1", pop_at(1), 32'h0000_0404);

    // redirect coincident with response, then PC wrap
    directed_knobs();
    reset_seq();
    redir_target = 32'hFFFF_FFFD; redir_on_rsp = 1;
    run(15);
    chk("t6_fired", redir_fired, 1);
    chk("t6_acc0", acc_at(0), 32'hFFFF_FFFC);
    chk("t6_acc1", acc_at(1), 32'h0);
    chk("t6_pop0", pop_at(0), 32'hFFFF_FFFC);
    chk("t6_pop0_plus4", p4_at(0), 32'h0);
    chk("t6_pop1", pop_at(1), 32'h0);

    // randomized soak
    directed_knobs();
    p_ready = 70; lat_min = 1; lat_max = 3; p_oready = 60; p_redir = 3; p_reset = 3;
    reset_seq();
    total_pops = 0;
    run(4000);
    chk("soak_progress", total_pops > 200, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
